// File: rtl/alloc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alloc_pkg
// Description : Shared types and helpers for the allocator requester: slot
//               count, slot index type, requester state encoding and the
//               free-slot / top-slot search functions over a QValid vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alloc_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } req_state_e;

  // Lowest clear bit: the slot the allocator fills next.
  function automatic slot_idx_t first_zero(input logic [NUM_SLOTS-1:0] v);
    slot_idx_t idx;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!v[i]) idx = slot_idx_t'(i);
    end
    return idx;
  endfunction

  // Highest set bit: the only slot the allocator can retire (LIFO order).
  function automatic slot_idx_t top_one(input logic [NUM_SLOTS-1:0] v);
    slot_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (v[i]) idx = slot_idx_t'(i);
    end
    return idx;
  endfunction

endpackage : alloc_pkg
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Per-slot lifetime down-counter. Loads a job length, then
//               decrements once per clock and saturates at zero. A slot is
//               retire-eligible while the counter reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_timer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_expired
);

  logic [LEN_W-1:0] r_cnt;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule : slot_timer
`default_nettype wire

// File: rtl/alloc_requester.sv
`default_nettype none
// ============================================================================
// Module      : alloc_requester
// Description : Initiator-side companion to the 4-entry thermometer slot
//               allocator. Accepts jobs over valid/ready, drives alloc and
//               dealloc strobes, times each slot's lifetime, retires slots
//               top-first, supports flush-drain and checks allocator QValid
//               against a shadow occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module alloc_requester
  import alloc_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  input  logic [LEN_W-1:0]     job_len,
  output logic                 job_ready,
  input  logic                 flush,
  output logic                 flush_done,
  input  logic [NUM_SLOTS-1:0] qvalid,
  output logic                 alloc,
  output logic                 dealloc,
  output logic                 retire_valid,
  output logic [1:0]           retire_slot,
  output logic [2:0]           busy_cnt,
  output logic                 proto_err
);

  req_state_e           r_state;
  req_state_e           w_state_nxt;
  logic [2:0]           r_shadow;
  logic                 r_flush_done;
  logic                 r_proto_err;

  logic [NUM_SLOTS-1:0] w_expired;
  logic [NUM_SLOTS-1:0] w_load;
  logic [NUM_SLOTS-1:0] w_qv_inc;
  slot_idx_t            w_top;
  slot_idx_t            w_free;
  logic                 w_any;
  logic                 w_full;
  logic                 w_dealloc;
  logic                 w_ready;
  logic                 w_alloc;
  logic                 w_err;

  assign w_top    = top_one(qvalid);
  assign w_free   = first_zero(qvalid);
  assign w_any    = (qvalid != '0);
  assign w_full   = (qvalid == '1);
  assign w_qv_inc = qvalid + NUM_SLOTS'(1);

  // Next state and strobes; dealloc wins over alloc so the allocator never
  // sees both in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_dealloc   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      RUN: begin
        w_dealloc = w_any && w_expired[w_top];
        w_ready   = !w_full && !w_dealloc;
        if (flush) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_dealloc = w_any;
        if (!w_any) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_alloc = job_valid && w_ready;

  // Mismatch against shadow count, or QValid not a thermometer code.
  assign w_err = ($countones(qvalid) != int'(r_shadow)) ||
                 ((qvalid & w_qv_inc) != '0);

  // State register plus the one-cycle drain-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == FLUSH) && !w_any;
    end
  end

  // Shadow occupancy follows our own strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_alloc) begin
      r_shadow <= r_shadow + 3'd1;
    end else if (w_dealloc) begin
      r_shadow <= r_shadow - 3'd1;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_err) begin
      r_proto_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign w_load[i] = w_alloc && (w_free == slot_idx_t'(i));
    slot_timer #(
      .LEN_W (LEN_W)
    ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load[i]),
      .i_len     (job_len),
      .o_expired (w_expired[i])
    );
  end

  assign job_ready    = w_ready;
  assign alloc        = w_alloc;
  assign dealloc      = w_dealloc;
  assign retire_valid = w_dealloc;
  assign retire_slot  = w_top;
  assign busy_cnt     = r_shadow;
  assign flush_done   = r_flush_done;
  assign proto_err    = r_proto_err;

endmodule : alloc_requester
`default_nettype wire

// File: tb/tb_alloc_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_alloc_requester
// Description : Self-checking bench for alloc_requester. The allocator is
//               modelled as a stack of jobs with remaining lifetimes; QValid
//               is driven from the stack depth one clock after each strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alloc_requester;

  logic       clk;
  logic       rst_n;
  logic       job_valid;
  logic [7:0] job_len;
  logic       job_ready;
  logic       flush;
  logic       flush_done;
  logic [3:0] qvalid;
  logic       alloc;
  logic       dealloc;
  logic       retire_valid;
  logic [1:0] retire_slot;
  logic [2:0] busy_cnt;
  logic       proto_err;

  alloc_requester #(.LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_len      (job_len),
    .job_ready    (job_ready),
    .flush        (flush),
    .flush_done   (flush_done),
    .qvalid       (qvalid),
    .alloc        (alloc),
    .dealloc      (dealloc),
    .retire_valid (retire_valid),
    .retire_slot  (retire_slot),
    .busy_cnt     (busy_cnt),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stack of jobs (index 0 = bottom), remaining cycles each.
  int   m_depth;
  int   m_rem [4];
  bit   m_flushing;
  bit   m_done;

  bit         cur_jv;
  logic [7:0] cur_len;
  bit         cur_fl;
  bit         e_ready, e_alloc, e_dealloc;
  logic [10:0] e_vec;
  logic [10:0] obs;

  assign obs = {job_ready, alloc, dealloc, retire_valid,
                (retire_valid ? retire_slot : 2'b00), busy_cnt, flush_done, proto_err};

  task automatic model_reset();
    m_depth = 0;
    m_flushing = 0;
    m_done = 0;
    for (int i = 0; i < 4; i++) m_rem[i] = 0;
  endtask

  // Drive one cycle's inputs mid-cycle and predict the combinational outputs.
  task automatic apply(input bit jv, input logic [7:0] jl, input bit fl);
    int top;
    @(negedge clk);
    job_valid = jv; job_len = jl; flush = fl;
    cur_jv = jv; cur_len = jl; cur_fl = fl;
    #1;
    top = m_depth - 1;
    e_dealloc = 0;
    if (m_depth > 0) e_dealloc = m_flushing ? 1'b1 : (m_rem[top] == 0);
    e_ready = !m_flushing && (m_depth < 4) && !e_dealloc;
    e_alloc = jv && e_ready;
    e_vec = {e_ready, e_alloc, e_dealloc, e_dealloc,
             (e_dealloc ? 2'(top) : 2'b00), 3'(m_depth), m_done, 1'b0};
  endtask

  // Clock edge: advance the model and the allocator's registered QValid.
  task automatic advance();
    @(posedge clk);
    #1;
    m_done = m_flushing && (m_depth == 0);
    if (m_flushing) m_flushing = (m_depth != 0);
    else            m_flushing = cur_fl;
    for (int i = 0; i < 4; i++) if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
    if (e_alloc) begin
      m_rem[m_depth] = int'(cur_len);
      m_depth = m_depth + 1;
    end else if (e_dealloc) begin
      m_depth = m_depth - 1;
    end
    qvalid = 4'((1 << m_depth) - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    job_valid = 0; job_len = 0; flush = 0; qvalid = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({job_ready, alloc, dealloc, retire_valid, busy_cnt, flush_done, proto_err} !== 9'b1_0_0_0_000_0_0)
      $display("FAIL reset_outputs: got rdy=%b al=%b de=%b rv=%b busy=%0d fd=%b pe=%b want rdy=1 rest 0",
               job_ready, alloc, dealloc, retire_valid, busy_cnt, flush_done, proto_err);
    else n_pass++;
  endtask

  task automatic test_single_job();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      apply(c == 0, 8'd2, 1'b0);
      n_checks++;
      if (obs !== e_vec) $display("FAIL single_job cyc %0d: got %b want %b", c, obs, e_vec);
      else n_pass++;
      if (c == 3) begin
        n_checks++;
        if (!(dealloc === 1'b1 && retire_slot === 2'd0))
          $display("FAIL single_job_retire: got de=%b slot=%0d want de=1 slot=0", dealloc, retire_slot);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lens [4];
    int idx = 0;
    int cyc = 0;
    lens[0] = 8'd10; lens[1] = 8'd0; lens[2] = 8'd0; lens[3] = 8'd20;
    do_reset();
    while ((idx < 4 || m_depth > 0) && cyc < 120) begin
      apply(idx < 4, (idx < 4) ? lens[idx] : 8'd0, 1'b0);
      n_checks++;
      if (obs !== e_vec) $display("FAIL back_to_back cyc %0d: got %b want %b", cyc, obs, e_vec);
      else n_pass++;
      advance();
      if (e_alloc) idx++;
      cyc++;
    end
    n_checks++;
    if (idx != 4 || m_depth != 0) $display("FAIL back_to_back_timeout: accepted %0d want 4, depth %0d want 0", idx, m_depth);
    else n_pass++;
  endtask

  task automatic test_dealloc_priority();
    do_reset();
    apply(1'b1, 8'd0, 1'b0);
    advance();
    apply(1'b1, 8'd5, 1'b0);
    n_checks++;
    if ({dealloc, alloc, job_ready} !== 3'b100)
      $display("FAIL dealloc_priority: got de=%b al=%b rdy=%b want de=1 al=0 rdy=0", dealloc, alloc, job_ready);
    else n_pass++;
    advance();
    apply(1'b1, 8'd5, 1'b0);
    n_checks++;
    if (obs !== e_vec || alloc !== 1'b1) $display("FAIL dealloc_then_accept: got %b want %b", obs, e_vec);
    else n_pass++;
    advance();
  endtask

  task automatic test_flush();
    int pulses = 0;
    int cyc = 0;
    do_reset();
    while (m_depth < 3 && cyc < 20) begin
      apply(1'b1, 8'd200, 1'b0);
      advance();
      cyc++;
    end
    for (int c = 0; c < 9; c++) begin
      apply(1'b1, 8'd7, c == 0);
      n_checks++;
      if (obs !== e_vec) $display("FAIL flush cyc %0d: got %b want %b", c, obs, e_vec);
      else n_pass++;
      if (flush_done === 1'b1) pulses++;
      advance();
    end
    n_checks++;
    if (pulses != 1) $display("FAIL flush_done_pulses: got %0d want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_random();
    bit pend = 0;
    logic [7:0] plen = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!pend && ($urandom % 3 == 0)) begin
        pend = 1;
        plen = 8'($urandom % 12);
      end
      apply(pend, plen, ($urandom % 40) == 0);
      n_checks++;
      if (obs !== e_vec) $display("FAIL random cyc %0d: got %b want %b", c, obs, e_vec);
      else n_pass++;
      advance();
      if (e_alloc) pend = 0;
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    @(negedge clk);
    qvalid = 4'b0101;
    #1;
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL proto_pre_edge: got %b want 0", proto_err);
    else n_pass++;
    @(posedge clk); #1;
    qvalid = 4'b0000;
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL proto_non_thermo: got %b want 1", proto_err);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", proto_err);
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL proto_reset_clear: got %b want 0", proto_err);
    else n_pass++;
    apply(1'b1, 8'd50, 1'b0);
    advance();
    apply(1'b0, 8'd0, 1'b0);
    n_checks++;
    if (proto_err !== 1'b0 || busy_cnt !== 3'd1) $display("FAIL proto_consistent: got pe=%b busy=%0d want pe=0 busy=1", proto_err, busy_cnt);
    else n_pass++;
    qvalid = 4'b0011;
    @(posedge clk); #1;
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL proto_count_mismatch: got %b want 1", proto_err);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 8'd30, 1'b0);
      advance();
    end
    @(negedge clk);
    #2;
    job_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    qvalid = 4'b0000;
    model_reset();
    #1;
    n_checks++;
    if ({job_ready, alloc, dealloc, retire_valid, busy_cnt, flush_done, proto_err} !== 9'b1_0_0_0_000_0_0)
      $display("FAIL async_reset: got rdy=%b al=%b de=%b rv=%b busy=%0d fd=%b pe=%b want rdy=1 rest 0",
               job_ready, alloc, dealloc, retire_valid, busy_cnt, flush_done, proto_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply(c == 0, 8'd1, 1'b0);
      n_checks++;
      if (obs !== e_vec) $display("FAIL after_async_reset cyc %0d: got %b want %b", c, obs, e_vec);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    job_valid = 0; job_len = 0; flush = 0; qvalid = 4'b0000;
    model_reset();
    test_reset();
    test_single_job();
    test_back_to_back();
    test_dealloc_priority();
    test_flush();
    test_random();
    test_proto_err();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alloc_requester
`default_nettype wire
